// File: rtl/gpio_in_irq.sv
`default_nettype none
// ============================================================================
// Module   : gpio_in_irq
// Brief    : Per-bit glitch filter, edge capture into W1C status, masked IRQ.
// Revision : 1.0
// ============================================================================
module gpio_in_irq #(
    parameter int WIDTH = 32,
    parameter int DIV   = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] aux_i,
    input  logic             cfg_en,
    input  logic [WIDTH-1:0] irq_rise_en,
    input  logic [WIDTH-1:0] irq_fall_en,
    input  logic [WIDTH-1:0] irq_mask,
    input  logic [WIDTH-1:0] irq_clr,
    output logic [WIDTH-1:0] aux_filt,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq
);

    localparam int             c_cnt_w    = (DIV <= 1) ? 1 : $clog2(DIV);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_s0;
    logic [WIDTH-1:0]   r_s1;
    logic [WIDTH-1:0]   r_filt;
    logic [WIDTH-1:0]   r_filt_d;
    logic [WIDTH-1:0]   r_status;
    logic               r_irq;

    logic               w_tick;
    logic [WIDTH-1:0]   w_agree;
    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_fall;
    logic [WIDTH-1:0]   w_set;

    assign w_tick  = cfg_en && (r_cnt == c_cnt_last);
    // A bit qualifies only when the live input matches both stored tick samples.
    assign w_agree = ~(aux_i ^ r_s0) & ~(r_s0 ^ r_s1);
    assign w_rise  = r_filt & ~r_filt_d;
    assign w_fall  = ~r_filt & r_filt_d;
    assign w_set   = {WIDTH{cfg_en}} & ((w_rise & irq_rise_en) | (w_fall & irq_fall_en));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_cnt <= '0;
        end else if (!cfg_en || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_s0   <= '0;
            r_s1   <= '0;
            r_filt <= '0;
        end else if (w_tick) begin
            r_s0   <= aux_i;
            r_s1   <= r_s0;
            r_filt <= (w_agree & aux_i) | (~w_agree & r_filt);
        end
    end

    // Set is OR-ed after the clear so a coincident set wins.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_filt_d <= '0;
            r_status <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_filt_d <= r_filt;
            r_status <= (r_status & ~irq_clr) | w_set;
            r_irq    <= |(r_status & irq_mask);
        end
    end

    assign aux_filt   = r_filt;
    assign irq_status = r_status;
    assign irq        = r_irq;

endmodule
`default_nettype wire

// File: doc/gpio_in_irq.md
Name: gpio_in_irq

Overview:
- Downstream stage of the aux input register; consumes the registered 32-bit `aux_i` word.
- Glitch-filters each bit on a prescaled sample tick and produces a stable `aux_filt` word.
- Detects rising and falling edges per bit and latches them into a sticky write-1-to-clear status register.
- Drives one masked, registered interrupt line to the system interrupt controller.

Parameters:
- WIDTH, 32, number of GPIO bits.
- DIV, 4, sample-tick prescale. Legal range 1..65535; DIV=1 gives a tick every cycle.

Ports:
- sys_clk  input  1  system clock, rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- aux_i  input  WIDTH  registered GPIO input word from the aux input stage.
- cfg_en  input  1  block enable. 0 freezes the prescaler and suppresses new status sets.
- irq_rise_en  input  WIDTH  per-bit enable for rising-edge capture.
- irq_fall_en  input  WIDTH  per-bit enable for falling-edge capture.
- irq_mask  input  WIDTH  per-bit interrupt enable (1 = bit contributes to irq).
- irq_clr  input  WIDTH  single-cycle write-1-to-clear strobe for status.
- aux_filt  output  WIDTH  filtered input word.
- irq_status  output  WIDTH  sticky edge status.
- irq  output  1  registered interrupt request.

Behaviour:
- Reset:
  - Applies on any sys_clk edge with sys_rst=1, including mid-operation.
  - Prescaler count, sample regs s0/s1, aux_filt, filt_d, irq_status and irq all go to 0.
- Prescaler:
  - Counter cnt runs 0..DIV-1 and wraps to 0.
  - tick=1 in the cycle cnt==DIV-1.
  - cfg_en=0 holds cnt at 0 and forces tick=0.
- Sampling, on tick:
  - s1<=s0, s0<=aux_i.
  - Per bit, if aux_i==s0==s1 (old values), aux_filt<=aux_i; otherwise aux_filt holds.
  - A bit therefore changes only after 3 consecutive equal tick samples.
  - Pulses shorter than 2*DIV cycles are rejected.
- Edge detect:
  - filt_d<=aux_filt every cycle.
  - rise=aux_filt&~filt_d; fall=~aux_filt&filt_d.
  - set = cfg_en & ((rise&irq_rise_en)|(fall&irq_fall_en)).
- Status: each cycle irq_status <= (irq_status & ~irq_clr) | set.
  - A set and a clear on the same bit in the same cycle leaves the bit 1 (set wins).
  - Clearing an already-0 bit has no effect.
- Interrupt:
  - irq <= |(irq_status & irq_mask), registered.
  - Masking does not alter irq_status.
  - Unmasking a pending bit raises irq on the next edge.
- Latency:
  - aux_filt to irq_status: 1 cycle after the aux_filt change edge.
  - irq_status to irq: 1 further cycle.
- Enable transitions:
  - cfg_en 1->0 mid-count restarts the prescaler from 0 when re-enabled.
  - While disabled, s0, s1 and aux_filt hold; irq_clr still works.
- Width rules:
  - cnt width = max(1, clog2(DIV)).
  - Comparison cnt==DIV-1 is done at cnt width; no overflow past DIV-1.

Test Plan:
- Reset release with DIV=4, cfg_en=1, aux_i=32'h0000_0001, irq_rise_en=all-ones, irq_mask=all-ones -> ticks at cycles 3, 7, 11; aux_filt=32'h1 after cycle 11; irq_status=32'h1 at cycle 12; irq=1 at cycle 13.
- Glitch: aux_i bit4 high for 6 cycles only (spanning 1-2 ticks) -> aux_filt bit4 never changes, irq_status stays 0.
- Fall capture: filtered bit0=1, irq_fall_en=32'h1, irq_rise_en=0; drop aux_i to 0 -> after 3 ticks aux_filt=0, irq_status bit0=1, irq=1.
- Clear:
  - One-cycle irq_clr=32'h1 with no new edge -> irq_status=0 next cycle, irq=0 the cycle after.
  - irq_clr=32'h1 in the same cycle as a new set on bit0 -> bit0 remains 1.
- Mask: irq_status=32'h8000_0000 with irq_mask=0 -> irq=0; set mask bit31 -> irq=1 one cycle later, status unchanged.
- Reset mid-operation after status=32'hDEAD_BEEF -> sys_rst for 1 cycle zeroes aux_filt, irq_status and irq; the filter refills, and re-qualifying aux_i=32'hDEAD_BEEF with all edges enabled re-sets status to 32'hDEAD_BEEF.
- Disable: cfg_en=0 while aux_i toggles -> aux_filt and irq_status frozen; irq_clr still clears.
